// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Optional feature macro: DMEM_FIXED_PRIO_EN (see dmem_rr_picker).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // A word access is legal when word aligned and the whole word fits in memory.
  function automatic logic word_legal(input logic [31:0] address, input int mem_bytes);
    logic [31:0] lim;
    lim = 32'(mem_bytes - 4);
    return (address[1:0] == 2'b00) && (address <= lim);
  endfunction

endpackage

// File: rtl/dmem_rr_picker.sv
// Combinational grant selection between port A and port B.
// DMEM_FIXED_PRIO_EN defined: A always wins a tie; otherwise round-robin on last_grant.
module dmem_rr_picker
  import dmem_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_port
);

`ifdef DMEM_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Pick a port: single requester wins outright, a tie goes by priority policy.
  always_comb begin
    gnt_valid = a_req | b_req;
    gnt_port  = PORT_A;
    if (a_req && b_req) begin
`ifdef DMEM_FIXED_PRIO_EN
      gnt_port = PORT_A;
`else
      gnt_port = ~last_grant;
`endif
    end else if (b_req) begin
      gnt_port = PORT_B;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single big-endian 32-bit data memory.
// Each access holds its strobe for WAIT_CYCLES cycles, then acks for one cycle.
// Misaligned / out-of-range requests are acked with err and never touch memory.
// Optional feature macro: DMEM_FIXED_PRIO_EN (fixed A-over-B priority on ties).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 3,
  parameter int MEM_BYTES   = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_address,
  input  logic [31:0] a_write_data,
  output logic [31:0] a_data,
  output logic        a_ack,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_address,
  input  logic [31:0] b_write_data,
  output logic [31:0] b_data,
  output logic        b_ack,
  output logic        b_err,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] data
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_q, gnt_d;
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   a_data_q, a_data_d;
  logic [31:0]   b_data_q, b_data_d;

  logic          pick_valid, pick_port;
  logic          req_we;
  logic [31:0]   req_addr, req_wdata;

  dmem_rr_picker u_picker (
    .a_req      (a_req),
    .b_req      (b_req),
    .last_grant (last_grant_q),
    .gnt_valid  (pick_valid),
    .gnt_port   (pick_port)
  );

  // Route the picked port's request fields toward the latch registers.
  always_comb begin
    req_we    = a_we;
    req_addr  = a_address;
    req_wdata = a_write_data;
    if (pick_port == PORT_B) begin
      req_we    = b_we;
      req_addr  = b_address;
      req_wdata = b_write_data;
    end
  end

  // Next-state logic: grant and latch in IDLE, time the access, ack in DONE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    a_data_d     = a_data_q;
    b_data_d     = b_data_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d        = pick_port;
          last_grant_d = pick_port;
          we_d         = req_we;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          if (word_legal(req_addr, MEM_BYTES)) begin
            state_d = ACCESS;
            cnt_d   = CW'(WAIT_CYCLES - 1);
            err_d   = 1'b0;
          end else begin
            // Rejected: skip memory entirely, the port sees 0 data with err.
            state_d = DONE;
            err_d   = 1'b1;
            if (pick_port == PORT_A) a_data_d = '0;
            else                     b_data_d = '0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (gnt_q == PORT_A) a_data_d = we_q ? 32'h0 : data;
          else                 b_data_d = we_q ? 32'h0 : data;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; last_grant resets to B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gnt_q        <= PORT_A;
      last_grant_q <= PORT_B;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      a_data_q     <= '0;
      b_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      a_data_q     <= a_data_d;
      b_data_q     <= b_data_d;
    end
  end

  // Strobes and acks decode from registered state, so reset kills them at once.
  assign mem_read   = (state_q == ACCESS) && !we_q;
  assign mem_write  = (state_q == ACCESS) &&  we_q;
  assign address    = addr_q;
  assign write_data = wdata_q;
  assign a_ack      = (state_q == DONE) && (gnt_q == PORT_A);
  assign b_ack      = (state_q == DONE) && (gnt_q == PORT_B);
  assign a_err      = a_ack && err_q;
  assign b_err      = b_ack && err_q;
  assign a_data     = a_data_q;
  assign b_data     = b_data_q;

endmodule
